// File: rtl/rf_pkg.sv
// Shared definitions for the register file.
//   DATA_W    - register and data-port width
//   ADDR_W    - register select width
//   NREGS     - number of registers (always 2**ADDR_W)
//   reg_idx_t - register index type
package rf_pkg;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;
    localparam int NREGS  = 2 ** ADDR_W;

    typedef logic [ADDR_W-1:0] reg_idx_t;
endpackage

// File: rtl/rf_read_mux.sv
// Combinational read multiplexer: selects one register out of the flattened
// register array. It has no state; the caller registers the result.
// Ports:
//   I_regs - all registers, entry i at I_regs[i]
//   I_sel  - register index
//   O_data - selected register contents
module rf_read_mux #(
    parameter int DATA_W = rf_pkg::DATA_W,
    parameter int ADDR_W = rf_pkg::ADDR_W,
    parameter int NREGS  = rf_pkg::NREGS
) (
    input  logic [NREGS-1:0][DATA_W-1:0] I_regs,
    input  logic [ADDR_W-1:0]            I_sel,
    output logic [DATA_W-1:0]            O_data
);
    // ADDR_W and NREGS are tied together (NREGS == 2**ADDR_W), so every
    // select value names a real register.
    assign O_data = I_regs[I_sel];
endmodule

// File: rtl/register_file.sv
// 8 x 16 general-purpose register file with two registered read ports (A, B)
// and one write port (D), all gated by a pipeline-stage enable.
// Ports:
//   I_clk   - clock; all state changes on the rising edge
//   I_rst   - synchronous active-high reset; clears registers and outputs
//   I_en    - stage enable; when low, nothing changes
//   I_we    - write enable, qualified by I_en
//   I_selA  - read port A index
//   I_selB  - read port B index
//   I_selD  - write port index
//   I_dataD - write data
//   O_dataA - registered read data, port A
//   O_dataB - registered read data, port B
// Reads sample the pre-edge register contents. A read that collides with a
// write to the same index returns the old value; there is no bypass.
module register_file #(
    parameter int DATA_W = rf_pkg::DATA_W,
    parameter int ADDR_W = rf_pkg::ADDR_W,
    parameter int NREGS  = rf_pkg::NREGS
) (
    input  logic              I_clk,
    input  logic              I_rst,
    input  logic              I_en,
    input  logic              I_we,
    input  logic [ADDR_W-1:0] I_selA,
    input  logic [ADDR_W-1:0] I_selB,
    input  logic [ADDR_W-1:0] I_selD,
    input  logic [DATA_W-1:0] I_dataD,
    output logic [DATA_W-1:0] O_dataA,
    output logic [DATA_W-1:0] O_dataB
);
    localparam int NPORTS = 2;

    logic [NREGS-1:0][DATA_W-1:0] regs_q;
    logic [NREGS-1:0][DATA_W-1:0] regs_d;

    logic [DATA_W-1:0] data_a_q, data_a_d;
    logic [DATA_W-1:0] data_b_q, data_b_d;

    logic              write_go;
    logic [ADDR_W-1:0] rd_sel  [NPORTS];
    logic [DATA_W-1:0] rd_data [NPORTS];

    assign write_go = I_en & I_we;

    // Per-register write decode: only the addressed entry takes new data.
    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_wr
            assign regs_d[gi] = (write_go && (I_selD == ADDR_W'(gi)))
                              ? I_dataD : regs_q[gi];
        end
    endgenerate

    assign rd_sel[0] = I_selA;
    assign rd_sel[1] = I_selB;

    // Read muxes look at regs_q (pre-edge contents), which is what gives
    // old-value-on-collision behaviour without any extra logic.
    generate
        for (gi = 0; gi < NPORTS; gi++) begin : g_rd
            rf_read_mux #(
                .DATA_W (DATA_W),
                .ADDR_W (ADDR_W),
                .NREGS  (NREGS)
            ) u_rd_mux (
                .I_regs (regs_q),
                .I_sel  (rd_sel[gi]),
                .O_data (rd_data[gi])
            );
        end
    endgenerate

    always_comb begin
        data_a_d = data_a_q;
        data_b_d = data_b_q;
        if (I_en) begin
            data_a_d = rd_data[0];
            data_b_d = rd_data[1];
        end
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            regs_q   <= '0;
            data_a_q <= '0;
            data_b_q <= '0;
        end else begin
            regs_q   <= regs_d;
            data_a_q <= data_a_d;
            data_b_q <= data_b_d;
        end
    end

    assign O_dataA = data_a_q;
    assign O_dataB = data_b_q;
endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file. A reference model of the register
// contents predicts each edge's outputs; predictions are queued when stimulus
// is applied and popped by the test tasks after the edge.
module tb_register_file;
    logic        I_clk = 1'b0;
    logic        I_rst = 1'b1;
    logic        I_en = 1'b0;
    logic        I_we = 1'b0;
    logic [2:0]  I_selA = '0, I_selB = '0, I_selD = '0;
    logic [15:0] I_dataD = '0;
    logic [15:0] O_dataA, O_dataB;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    logic [15:0] mdl [8];
    logic [15:0] mdl_a = '0, mdl_b = '0;

    register_file dut (
        .I_clk   (I_clk),
        .I_rst   (I_rst),
        .I_en    (I_en),
        .I_we    (I_we),
        .I_selA  (I_selA),
        .I_selB  (I_selB),
        .I_selD  (I_selD),
        .I_dataD (I_dataD),
        .O_dataA (O_dataA),
        .O_dataB (O_dataB)
    );

    always #5 I_clk = ~I_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: sim time exceeded, required finish");
        $fatal(1, "watchdog");
    end

    // Applies one edge of stimulus, predicts the outputs after that edge,
    // queues the prediction, then waits until just after the edge.
    task automatic cycle(input logic rst, input logic en, input logic we,
                         input logic [2:0] sa, input logic [2:0] sb,
                         input logic [2:0] sd, input logic [15:0] dd);
        I_rst = rst; I_en = en; I_we = we;
        I_selA = sa; I_selB = sb; I_selD = sd; I_dataD = dd;
        if (rst) begin
            for (int i = 0; i < 8; i++) mdl[i] = '0;
            mdl_a = '0; mdl_b = '0;
        end else if (en) begin
            mdl_a = mdl[sa];
            mdl_b = mdl[sb];
            if (we) mdl[sd] = dd;
        end
        exp_q.push_back('{a: mdl_a, b: mdl_b});
        @(posedge I_clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b1, 1'b1, 3'(i), 3'(7 - i), 3'(i), 16'h1000 + 16'(i) * 16'h0111);
            e = exp_q.pop_front(); total++;
            if (O_dataA !== e.a || O_dataB !== e.b) begin
                bad++;
                $display("FAIL reset_preload[%0d]: A=%h B=%h want A=%h B=%h", i, O_dataA, O_dataB, e.a, e.b);
            end
        end
        cycle(1'b0, 1'b1, 1'b0, 3'd3, 3'd6, 3'd0, 16'h0);
        e = exp_q.pop_front(); total++;
        if (O_dataA !== 16'h1333 || O_dataB !== 16'h1666) begin
            bad++;
            $display("FAIL reset_preload_read: A=%h B=%h want A=1333 B=1666", O_dataA, O_dataB);
        end
        cycle(1'b1, 1'b1, 1'b1, 3'd3, 3'd6, 3'd2, 16'hBEEF);
        e = exp_q.pop_front(); total++;
        if (O_dataA !== 16'h0000 || O_dataB !== 16'h0000) begin
            bad++;
            $display("FAIL reset_outputs: A=%h B=%h want A=0000 B=0000", O_dataA, O_dataB);
        end
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 3'(i), 3'(i + 4), 3'd0, 16'h0);
            e = exp_q.pop_front(); total++;
            if (O_dataA !== 16'h0000 || O_dataB !== 16'h0000) begin
                bad++;
                $display("FAIL reset_read[%0d,%0d]: A=%h B=%h want A=0000 B=0000", i, i + 4, O_dataA, O_dataB);
            end
        end
    endtask

    task automatic test_collision();
        cycle(1'b0, 1'b1, 1'b1, 3'd0, 3'd1, 3'd0, 16'hFFFF);
        e = exp_q.pop_front(); total++;
        if (O_dataA !== 16'h0000 || O_dataA !== e.a || O_dataB !== e.b) begin
            bad++;
            $display("FAIL collision_old: A=%h B=%h want A=0000 B=%h", O_dataA, O_dataB, e.b);
        end
        cycle(1'b0, 1'b1, 1'b0, 3'd0, 3'd1, 3'd0, 16'h0);
        e = exp_q.pop_front(); total++;
        if (O_dataA !== 16'hFFFF || O_dataB !== 16'h0000) begin
            bad++;
            $display("FAIL collision_new: A=%h B=%h want A=FFFF B=0000", O_dataA, O_dataB);
        end
    endtask

    task automatic test_we_gating();
        cycle(1'b0, 1'b1, 1'b0, 3'd2, 3'd2, 3'd2, 16'h2222);
        e = exp_q.pop_front(); total++;
        if (O_dataA !== e.a || O_dataB !== e.b) begin
            bad++;
            $display("FAIL we_gating_hold: A=%h B=%h want A=%h B=%h", O_dataA, O_dataB, e.a, e.b);
        end
        cycle(1'b0, 1'b1, 1'b1, 3'd2, 3'd2, 3'd2, 16'h3333);
        e = exp_q.pop_front(); total++;
        if (O_dataA !== 16'h0000 || O_dataB !== 16'h0000) begin
            bad++;
            $display("FAIL we_gating_r2_old: A=%h B=%h want A=0000 B=0000", O_dataA, O_dataB);
        end
        cycle(1'b0, 1'b1, 1'b0, 3'd2, 3'd0, 3'd2, 16'h5555);
        e = exp_q.pop_front(); total++;
        if (O_dataA !== 16'h3333 || O_dataB !== e.b) begin
            bad++;
            $display("FAIL we_gating_r2: A=%h B=%h want A=3333 B=%h", O_dataA, O_dataB, e.b);
        end
    endtask

    task automatic test_write_inhibit();
        cycle(1'b0, 1'b1, 1'b0, 3'd0, 3'd2, 3'd0, 16'hFEED);
        e = exp_q.pop_front(); total++;
        if (O_dataA !== 16'hFFFF || O_dataB !== e.b) begin
            bad++;
            $display("FAIL inhibit_r0_before: A=%h B=%h want A=FFFF B=%h", O_dataA, O_dataB, e.b);
        end
        cycle(1'b0, 1'b1, 1'b1, 3'd0, 3'd0, 3'd0, 16'h4444);
        e = exp_q.pop_front(); total++;
        if (O_dataA !== 16'hFFFF || O_dataB !== 16'hFFFF) begin
            bad++;
            $display("FAIL inhibit_r0_hold: A=%h B=%h want A=FFFF B=FFFF", O_dataA, O_dataB);
        end
        cycle(1'b0, 1'b1, 1'b0, 3'd0, 3'd2, 3'd0, 16'h0);
        e = exp_q.pop_front(); total++;
        if (O_dataA !== 16'h4444 || O_dataB !== 16'h3333) begin
            bad++;
            $display("FAIL inhibit_r0_new: A=%h B=%h want A=4444 B=3333", O_dataA, O_dataB);
        end
    endtask

    task automatic test_enable_low();
        logic [15:0] held_a, held_b;
        held_a = O_dataA; held_b = O_dataB;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  3'(i), 16'($urandom));
            e = exp_q.pop_front(); total++;
            if (O_dataA !== held_a || O_dataB !== held_b || O_dataA !== e.a) begin
                bad++;
                $display("FAIL enable_low_hold[%0d]: A=%h B=%h want A=%h B=%h", i, O_dataA, O_dataB, held_a, held_b);
            end
        end
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 3'(i), 3'(i + 4), 3'd0, 16'h0);
            e = exp_q.pop_front(); total++;
            if (O_dataA !== e.a || O_dataB !== e.b) begin
                bad++;
                $display("FAIL enable_low_regs[%0d,%0d]: A=%h B=%h want A=%h B=%h", i, i + 4, O_dataA, O_dataB, e.a, e.b);
            end
        end
    endtask

    task automatic test_dual_port();
        cycle(1'b0, 1'b1, 1'b1, 3'd0, 3'd0, 3'd4, 16'hABCD);
        void'(exp_q.pop_front());
        cycle(1'b0, 1'b1, 1'b0, 3'd4, 3'd4, 3'd0, 16'h0);
        e = exp_q.pop_front(); total++;
        if (O_dataA !== 16'hABCD || O_dataB !== 16'hABCD) begin
            bad++;
            $display("FAIL dual_same_index: A=%h B=%h want A=ABCD B=ABCD", O_dataA, O_dataB);
        end
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b1, 1'b1, 3'd0, 3'd0, 3'(i), {4{4'(i)}} ^ 16'h5A00);
            void'(exp_q.pop_front());
        end
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 3'(i), 3'(7 - i), 3'd0, 16'h0);
            e = exp_q.pop_front(); total++;
            if (O_dataA !== ({4{4'(i)}} ^ 16'h5A00) || O_dataB !== ({4{4'(7 - i)}} ^ 16'h5A00)) begin
                bad++;
                $display("FAIL sweep[%0d,%0d]: A=%h B=%h want A=%h B=%h", i, 7 - i, O_dataA, O_dataB, e.a, e.b);
            end
        end
    endtask

    task automatic test_back_to_back();
        cycle(1'b0, 1'b1, 1'b1, 3'd0, 3'd0, 3'd5, 16'h1111);
        void'(exp_q.pop_front());
        cycle(1'b0, 1'b1, 1'b1, 3'd5, 3'd0, 3'd5, 16'h5555);
        e = exp_q.pop_front(); total++;
        if (O_dataA !== 16'h1111) begin
            bad++;
            $display("FAIL b2b_first: A=%h want A=1111", O_dataA);
        end
        cycle(1'b0, 1'b1, 1'b0, 3'd5, 3'd5, 3'd0, 16'h0);
        e = exp_q.pop_front(); total++;
        if (O_dataA !== 16'h5555 || O_dataB !== 16'h5555) begin
            bad++;
            $display("FAIL b2b_last_wins: A=%h B=%h want A=5555 B=5555", O_dataA, O_dataB);
        end
        // Reset concurrent with a write: reset wins, r3 reads back zero.
        cycle(1'b1, 1'b1, 1'b1, 3'd5, 3'd5, 3'd3, 16'hDEAD);
        void'(exp_q.pop_front());
        cycle(1'b0, 1'b1, 1'b0, 3'd3, 3'd5, 3'd0, 16'h0);
        e = exp_q.pop_front(); total++;
        if (O_dataA !== 16'h0000 || O_dataB !== 16'h0000) begin
            bad++;
            $display("FAIL reset_over_write: A=%h B=%h want A=0000 B=0000", O_dataA, O_dataB);
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mdl[i] = '0;
        cycle(1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 16'h0);
        e = exp_q.pop_front(); total++;
        if (O_dataA !== 16'h0000 || O_dataB !== 16'h0000) begin
            bad++;
            $display("FAIL initial_reset: A=%h B=%h want A=0000 B=0000", O_dataA, O_dataB);
        end
        test_reset();
        test_collision();
        test_we_gating();
        test_write_inhibit();
        test_enable_low();
        test_dual_port();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
